// File: rtl/em_pipe_reg.sv
// -----------------------------------------------------------------------------
// em_pipe_reg -- EX/MEM pipeline register for the pipelined RV32I core.
//
// Purpose:
//   Carries the execute-stage result bundle into the data-memory stage behind
//   a valid/ready handshake. A two-entry store (main + skid) lets the MEM side
//   stall without losing or repeating an EX result, and without any
//   combinational path from ready_i back to ready_o.
//
// Handshake:
//   A transfer happens on a rising edge where valid and ready are both high on
//   the same side (accept = valid_i & ready_o, drain = valid_o & ready_i).
//   valid_o never drops without a drain (except flush/rst), payload is stable
//   while valid_o & !ready_i, and ready_o depends on registered state only.
//
// Parameters:
//   DATA_WIDTH  width of ALUResult, WriteData and PCPlus4 (default 32)
//   REG_ADDR_W  width of the destination register index Rd (default 5)
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             drop every held entry (bubble insert), next cycle EMPTY
//   valid_i/ready_o   EX-side handshake
//   *E inputs         EX-stage control and data fields
//   valid_o/ready_i   MEM-side handshake
//   *M outputs        registered copies of the *E fields (main entry)
//   stall_cycles      count of cycles with valid_o & !ready_i
//   dbg_state         current FSM state (0 EMPTY, 1 BUSY, 2 FULL)
//
// Configuration:
//   EM_PIPE_PERF_EN   when defined, builds the saturating stall_cycles
//                     counter; otherwise stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module em_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    // EX side
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  MemWriteE,
    input  logic [DATA_WIDTH-1:0] ALUResultE,
    input  logic [DATA_WIDTH-1:0] WriteDataE,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [DATA_WIDTH-1:0] PCPlus4E,

    // MEM side
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  RegWriteM,
    output logic [1:0]            ResultSrcM,
    output logic                  MemWriteM,
    output logic [DATA_WIDTH-1:0] ALUResultM,
    output logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [DATA_WIDTH-1:0] PCPlus4M,

    // Observability
    output logic [31:0]           stall_cycles,
    output logic [1:0]            dbg_state
);

    // -------------------------------------------------------------------------
    // Entry layout: every payload field travelling from EX to MEM.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] write_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_WIDTH-1:0] pc_plus4;
    } entry_t;

    // The state fully encodes both entry valid bits:
    //   EMPTY: main invalid, skid invalid
    //   BUSY : main valid,   skid invalid
    //   FULL : main valid,   skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;

    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;

    // An entry that becomes invalid loses its architectural side effects, so a
    // bubble can never write the register file or data memory. Data fields are
    // left alone; they are don't-care while the entry is invalid.
    function automatic entry_t kill(input entry_t e);
        entry_t r;
        r           = e;
        r.reg_write = 1'b0;
        r.mem_write = 1'b0;
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Input bundle
    // -------------------------------------------------------------------------
    always_comb begin
        in_entry            = '0;
        in_entry.reg_write  = RegWriteE;
        in_entry.result_src = ResultSrcE;
        in_entry.mem_write  = MemWriteE;
        in_entry.alu_result = ALUResultE;
        in_entry.write_data = WriteDataE;
        in_entry.rd         = RdE;
        in_entry.pc_plus4   = PCPlus4E;
    end

    // -------------------------------------------------------------------------
    // Handshake decode (registered state only on the ready_o path)
    // -------------------------------------------------------------------------
    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);

    assign valid_o = main_valid;
    assign ready_o = !skid_valid;

    assign accept = valid_i & ready_o;
    assign drain  = valid_o & ready_i;

    // -------------------------------------------------------------------------
    // FSM: next-state and entry update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush wins over accept and drain; the incoming instruction is
            // discarded along with everything held.
            state_d = EMPTY;
            main_d  = kill(main_q);
            skid_d  = kill(skid_q);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = BUSY;
                    end
                end

                BUSY: begin
                    if (accept && drain) begin
                        // Full-throughput case: old main leaves, new one lands.
                        main_d = in_entry;
                    end else if (drain) begin
                        main_d  = kill(main_q);
                        state_d = EMPTY;
                    end else if (accept) begin
                        // MEM stalled while EX still had a result in flight:
                        // park it behind main so arrival order is preserved.
                        skid_d  = in_entry;
                        state_d = FULL;
                    end
                end

                FULL: begin
                    // ready_o is low, so valid_i cannot be accepted here.
                    if (drain) begin
                        main_d  = skid_q;
                        skid_d  = kill(skid_q);
                        state_d = BUSY;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean bubble.
                    state_d = EMPTY;
                    main_d  = kill(main_q);
                    skid_d  = kill(skid_q);
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // -------------------------------------------------------------------------
    // MEM-side outputs come straight from the main entry
    // -------------------------------------------------------------------------
    assign RegWriteM  = main_q.reg_write;
    assign ResultSrcM = main_q.result_src;
    assign MemWriteM  = main_q.mem_write;
    assign ALUResultM = main_q.alu_result;
    assign WriteDataM = main_q.write_data;
    assign RdM        = main_q.rd;
    assign PCPlus4M   = main_q.pc_plus4;

    assign dbg_state  = state_q;

    // -------------------------------------------------------------------------
    // Stall performance counter
    // -------------------------------------------------------------------------
`ifdef EM_PIPE_PERF_EN
    logic        stall_now;
    logic [31:0] stall_q;

    assign stall_now = valid_o & ~ready_i;

    // Saturating; only rst clears it, flush leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/em_pipe_reg.md
Name: em_pipe_reg

Overview:
- Parametrised EX/MEM pipeline register for the pipelined RV32I core. Successor to the free-running EX→MEM latch.
- Adds synchronous reset, a valid/ready handshake, a flush (bubble insert), and a 2-entry skid buffer, so MEM-side back-pressure never drops or duplicates an EX result.
- Sits between the execute stage and the data-memory stage.

Parameters:
- DATA_WIDTH, 32, width of ALUResult, WriteData and PCPlus4.
- REG_ADDR_W, 5, width of the destination register index Rd.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill all held entries; insert bubble.
- valid_i  in  1  EX presents a valid instruction.
- ready_o  out  1  register can accept this cycle.
- RegWriteE  in  1  register-file write enable.
- ResultSrcE  in  2  writeback mux select.
- MemWriteE  in  1  data-memory write enable.
- ALUResultE  in  DATA_WIDTH  ALU result / memory address.
- WriteDataE  in  DATA_WIDTH  store data.
- RdE  in  REG_ADDR_W  destination register.
- PCPlus4E  in  DATA_WIDTH  PC+4 for jal/jalr writeback.
- valid_o  out  1  MEM-side entry valid.
- ready_i  in  1  MEM stage consumes the entry this cycle.
- RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M  out  widths as E-side  registered copies.
- stall_cycles  out  32  perf counter (see Optional Feature).

Behaviour:
- Storage: main entry (drives the M outputs) and skid entry. Each entry is all payload fields plus a valid bit.
- Accept = valid_i & ready_o. Drain = valid_o & ready_i.
- ready_o = !skid_valid. It is derived from registered state only; no combinational path from ready_i.
- State machine:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: both valid.
- Transitions (when not flushing):
  - EMPTY: accept → load main, go BUSY. Otherwise stay.
  - BUSY, accept & drain: main ← input, stay BUSY. Gives 1 instr/cycle, latency 1.
  - BUSY, drain only: go EMPTY.
  - BUSY, accept only: skid ← input, go FULL.
  - BUSY, neither: hold.
  - FULL: valid_i is ignored because ready_o=0. Drain → main ← skid, go BUSY. Otherwise hold.
- Invalid entries: RegWriteM and MemWriteM are forced to 0 whenever valid_o=0, by clearing the stored bits when an entry becomes invalid. Bubbles therefore have no architectural side effect. The data fields of an invalid entry keep their last value and are don't-care.
- flush (cycle after assertion):
  - state EMPTY; main and skid valid bits 0; RegWriteM=MemWriteM=0.
  - flush has priority over accept and drain in the same cycle; the incoming instruction is discarded.
- rst:
  - Same priority as flush, and above it.
  - All outputs 0 the cycle after: valid_o=0, ready_o=1, RegWriteM=0, ResultSrcM=0, MemWriteM=0, ALUResultM=0, WriteDataM=0, RdM=0, PCPlus4M=0, stall_cycles=0.
  - Reset mid-FULL drops both entries.
- Ordering: entries leave strictly in arrival order. An entry sitting in skid never overtakes main.
- No arithmetic on payload. All widths pass through unchanged.

Optional Feature:
- Macro: EM_PIPE_PERF_EN.
- Defined: stall_cycles increments by 1 on every cycle with valid_o=1 & ready_i=0.
  - Saturates at 0xFFFF_FFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Stream: rst, then 4 back-to-back valid_i with ALUResultE=0x10,0x14,0x18,0x1C and ready_i=1 → ALUResultM shows the same sequence one cycle later each; valid_o=1 for 4 cycles; ready_o stays 1.
- Back-pressure: with BUSY holding 0x10, drop ready_i and present 0x14 → next cycle ready_o=0 (FULL) and M outputs still 0x10. Present 0x18 while FULL → ignored. Raise ready_i → outputs 0x14, then 0x18 never appears.
- Flush: in FULL with MemWriteE=1 entries, assert flush together with valid_i → next cycle valid_o=0, MemWriteM=0, RegWriteM=0, ready_o=1; the flushed instruction is never emitted.
- Reset mid-operation: in FULL with RdM=5'd7, assert rst → all outputs 0, ready_o=1. After release, a new entry RdE=3 appears as RdM=3 with latency 1.
- Perf (EM_PIPE_PERF_EN defined): hold valid_o=1, ready_i=0 for 10 cycles → stall_cycles=10. A flush leaves 10. rst → 0. Without the macro, stall_cycles=0 throughout.
